// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline stages.
//   ALU_*  : 3-bit ALU operation codes driven on ALUControlE.
//   FWD_*  : 2-bit forwarding select codes driven by the hazard unit.
//   ex_mem_t : contents of the EX/MEM pipeline register.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] write_data;
        logic [31:0] alu_result;
    } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU.
//   A, B       : operands
//   ALUControl : operation select (riscv_pkg ALU_* codes)
//   Result     : operation result, mod 2^32; unknown codes give 0
//   Zero       : high when Result == 0
module alu
    import riscv_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {31'b0, $signed(A) < $signed(B)};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of a 5-stage RISC-V pipeline with the EX/MEM register.
//   clk, rst             : rising-edge clock, asynchronous active-low reset
//   *E inputs            : decoded controls, operands and PC values
//   ResultW, Forward*_E  : writeback value and hazard-unit forwarding selects
//   PCSrcE, PCTargetE    : combinational branch decision / target
//   *M outputs           : EX/MEM register contents (1-cycle latency)
// Build option: define EXEC_FORWARD_EN to enable operand forwarding; when
// undefined the forwarding inputs are ignored and RD1_E/RD2_E are used as-is.
module execute_cycle
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALUResultM
);

    logic [31:0] src_a_e, fwd_b_e, src_b_e, alu_result_e;
    logic        zero_e;
    ex_mem_t     ex_mem_d, ex_mem_q;

`ifdef EXEC_FORWARD_EN
    // MEM forwarding taps the registered result, so an instruction sees the
    // value of the one before it, never its own same-edge update.
    always_comb begin
        case (ForwardA_E)
            FWD_WB:  src_a_e = ResultW;
            FWD_MEM: src_a_e = ex_mem_q.alu_result;
            default: src_a_e = RD1_E;
        endcase
        case (ForwardB_E)
            FWD_WB:  fwd_b_e = ResultW;
            FWD_MEM: fwd_b_e = ex_mem_q.alu_result;
            default: fwd_b_e = RD2_E;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};
    assign src_a_e    = RD1_E;
    assign fwd_b_e    = RD2_E;
`endif

    assign src_b_e = ALUSrcE ? Imm_Ext_E : fwd_b_e;

    alu u_alu (
        .A          (src_a_e),
        .B          (src_b_e),
        .ALUControl (ALUControlE),
        .Result     (alu_result_e),
        .Zero       (zero_e)
    );

    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Store data is the register operand, not the immediate.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.rd         = RD_E;
        ex_mem_d.pc_plus4   = PCPlus4E;
        ex_mem_d.write_data = fwd_b_e;
        ex_mem_d.alu_result = alu_result_e;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ex_mem_q <= '0;
        else      ex_mem_q <= ex_mem_d;
    end

    assign RegWriteM  = ex_mem_q.reg_write;
    assign MemWriteM  = ex_mem_q.mem_write;
    assign ResultSrcM = ex_mem_q.result_src;
    assign RD_M       = ex_mem_q.rd;
    assign PCPlus4M   = ex_mem_q.pc_plus4;
    assign WriteDataM = ex_mem_q.write_data;
    assign ALUResultM = ex_mem_q.alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vector table, hand-written reset
// sequence, then randomized vectors against a behavioural model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALUResultM;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALUResultM(ALUResultM)
    );

    typedef struct {
        logic        br, asrc;
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, imm, pce, resw;
        logic [31:0] exp_alu, exp_wd;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic br, logic asrc, logic [2:0] op,
                                logic [1:0] fa, logic [1:0] fb,
                                logic [31:0] rd1, logic [31:0] rd2,
                                logic [31:0] imm, logic [31:0] pce,
                                logic [31:0] resw, logic [31:0] exp_alu,
                                logic [31:0] exp_wd, logic exp_pcsrc,
                                logic [31:0] exp_tgt);
        vec_t v;
        v.br = br; v.asrc = asrc; v.op = op; v.fa = fa; v.fb = fb;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pce = pce; v.resw = resw;
        v.exp_alu = exp_alu; v.exp_wd = exp_wd;
        v.exp_pcsrc = exp_pcsrc; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a,
                                            logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(logic [1:0] sel, logic [31:0] rf,
                                            logic [31:0] wb, logic [31:0] mem);
`ifdef EXEC_FORWARD_EN
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
`endif
        return rf;
    endfunction

    task automatic drive(logic rw, logic mw, logic rs, logic [4:0] rd,
                         logic [31:0] pc4, vec_t v);
        RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; RD_E = rd;
        PCPlus4E = pc4; BranchE = v.br; ALUSrcE = v.asrc; ALUControlE = v.op;
        ForwardA_E = v.fa; ForwardB_E = v.fb; RD1_E = v.rd1; RD2_E = v.rd2;
        Imm_Ext_E = v.imm; PCE = v.pce; ResultW = v.resw;
    endtask

    task automatic chk_m_zero(string tag);
        chk({tag, " RegWriteM"},  {31'b0, RegWriteM},  32'd0);
        chk({tag, " MemWriteM"},  {31'b0, MemWriteM},  32'd0);
        chk({tag, " ResultSrcM"}, {31'b0, ResultSrcM}, 32'd0);
        chk({tag, " RD_M"},       {27'b0, RD_M},       32'd0);
        chk({tag, " PCPlus4M"},   PCPlus4M,            32'd0);
        chk({tag, " WriteDataM"}, WriteDataM,          32'd0);
        chk({tag, " ALUResultM"}, ALUResultM,          32'd0);
    endtask

    initial begin
        logic [31:0] m_alu;
        logic [31:0] e6_alu, e7_alu, e7_wd;
        vec_t v;

`ifdef EXEC_FORWARD_EN
        e6_alu = 32'h0000000D; e7_alu = 32'h0000000C; e7_wd = 32'h0000000A;
`else
        e6_alu = 32'h00000065; e7_alu = 32'h00000035; e7_wd = 32'h00000033;
`endif
        //           br asrc op   fa  fb  rd1          rd2          imm          pce          resw   alu          wd           pcs tgt
        tbl.push_back(mk(0, 0, 3'd0, 0, 0, 32'd5,        32'd7,        32'd0,        32'd0,        0, 32'h0000000C, 32'd7,        0, 32'd0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 0, 32'd3,        32'h11,       32'd5,        32'd0,        0, 32'hFFFFFFFE, 32'h11,       0, 32'd5));
        tbl.push_back(mk(0, 1, 3'd5, 0, 0, 32'd3,        32'h11,       32'd5,        32'd0,        0, 32'h00000001, 32'h11,       0, 32'd5));
        tbl.push_back(mk(1, 0, 3'd1, 0, 0, 32'd9,        32'd9,        32'd8,        32'h10,       0, 32'd0,        32'd9,        1, 32'h18));
        tbl.push_back(mk(1, 0, 3'd1, 0, 0, 32'd9,        32'd8,        32'd8,        32'h10,       0, 32'd1,        32'd8,        0, 32'h18));
        tbl.push_back(mk(0, 0, 3'd0, 0, 0, 32'd5,        32'd7,        32'd0,        32'd0,        0, 32'h0000000C, 32'd7,        0, 32'd0));
        tbl.push_back(mk(0, 0, 3'd0, 2, 0, 32'h64,       32'd1,        32'd0,        32'd0,        0, e6_alu,       32'd1,        0, 32'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 1, 32'd2,        32'h33,       32'd0,        32'd0,      'hA, e7_alu,       e7_wd,        0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h20,       32'hFFFFFFF0, 0, 32'd0,        32'd1,        1, 32'h10));
        tbl.push_back(mk(0, 0, 3'd5, 0, 0, 32'h80000000, 32'd1,        32'd0,        32'd0,        0, 32'd1,        32'd1,        0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd5, 0, 0, 32'd1,        32'h80000000, 32'd4,        32'd0,        0, 32'd0,        32'h80000000, 1, 32'd4));
        tbl.push_back(mk(0, 0, 3'd2, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'd0,        0, 32'h00F000F0, 32'h0FF00FF0, 0, 32'd0));
        tbl.push_back(mk(0, 0, 3'd3, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'd0,        0, 32'hFFF0FFF0, 32'h0FF00FF0, 0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd7, 0, 0, 32'd5,        32'd5,        32'd0,        32'd0,        0, 32'd0,        32'd5,        1, 32'd0));
        tbl.push_back(mk(0, 0, 3'd4, 0, 0, 32'd5,        32'd6,        32'd0,        32'd0,        0, 32'd0,        32'd6,        0, 32'd0));
        tbl.push_back(mk(0, 0, 3'd0, 3, 3, 32'd4,        32'd4,        32'd0,        32'd0,     'h77, 32'd8,        32'd4,        0, 32'd0));

        // Reset state, checked before any clock edge.
        rst = 1'b0;
        drive(1, 1, 1, 5'd3, 32'h44, tbl[0]);
        #2;
        chk_m_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(i[0], i[1], i[2], 5'(i), 32'h1000 + 32'(4 * i), tbl[i]);
            #1;
            chk($sformatf("v%0d PCSrcE", i), {31'b0, PCSrcE}, {31'b0, tbl[i].exp_pcsrc});
            chk($sformatf("v%0d PCTargetE", i), PCTargetE, tbl[i].exp_tgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ALUResultM", i), ALUResultM, tbl[i].exp_alu);
            chk($sformatf("v%0d WriteDataM", i), WriteDataM, tbl[i].exp_wd);
            chk($sformatf("v%0d ctrlM", i), {29'b0, RegWriteM, MemWriteM, ResultSrcM},
                {29'b0, i[0], i[1], i[2]});
            chk($sformatf("v%0d RD_M", i), {27'b0, RD_M}, 32'(i[4:0]));
            chk($sformatf("v%0d PCPlus4M", i), PCPlus4M, 32'h1000 + 32'(4 * i));
        end

        // Mid-cycle reset discards the in-flight instruction.
        @(negedge clk);
        v = mk(0, 0, 3'd0, 0, 0, 32'd1, 32'd2, 32'd16, 32'h100, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 5'd9, 32'h2000, v);
        @(posedge clk);
        #1;
        chk("pre-reset RegWriteM", {31'b0, RegWriteM}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_m_zero("async reset");
        chk("reset PCTargetE", PCTargetE, 32'h110);
        @(posedge clk);
        #1;
        chk_m_zero("held reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_m_zero("released");
        @(posedge clk);
        #1;
        chk("post-reset ALUResultM", ALUResultM, 32'd3);
        chk("post-reset RegWriteM", {31'b0, RegWriteM}, 32'd1);
        m_alu = 32'd3;

        // Randomized vectors against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b, bb, exp_r;
            logic        rw, mw, rs;
            logic [4:0]  rd;
            logic [31:0] pc4;
            @(negedge clk);
            v.br = 1'($urandom); v.asrc = 1'($urandom); v.op = 3'($urandom);
            v.fa = 2'($urandom); v.fb = 2'($urandom);
            v.rd1 = $urandom; v.imm = $urandom; v.pce = $urandom; v.resw = $urandom;
            v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
            rw = 1'($urandom); mw = 1'($urandom); rs = 1'($urandom);
            rd = 5'($urandom); pc4 = $urandom;
            drive(rw, mw, rs, rd, pc4, v);
            a     = ref_fwd(v.fa, v.rd1, v.resw, m_alu);
            bb    = ref_fwd(v.fb, v.rd2, v.resw, m_alu);
            b     = v.asrc ? v.imm : bb;
            exp_r = ref_alu(v.op, a, b);
            #1;
            chk("rnd PCSrcE", {31'b0, PCSrcE}, {31'b0, v.br && (exp_r == 0)});
            chk("rnd PCTargetE", PCTargetE, v.pce + v.imm);
            @(posedge clk);
            #1;
            chk("rnd ALUResultM", ALUResultM, exp_r);
            chk("rnd WriteDataM", WriteDataM, bb);
            chk("rnd ctrlM", {24'b0, RD_M, RegWriteM, MemWriteM, ResultSrcM},
                {24'b0, rd, rw, mw, rs});
            chk("rnd PCPlus4M", PCPlus4M, pc4);
            m_alu = exp_r;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
